ctrl_cct_kw_store: RTL and testbench
====================================

// Module: ctrl_cct_kw_store
// PURPOSE
//  Write-side controller for the kernel-weight memory read by the convolution load path.
//  Accepts a burst of 8 weights over a valid/ready stream for a selected filter size F.
//  Writes them to that F's region: addresses 8*F+1 .. 8*F+8 (F=0 -> 1..8, F=7 -> 57..64).
//  Sits between the host/config interface and the kernel-weight RAM; address 0 is never written.
// PARAMETERS
//  DATA_W   8   weight word width
//  ADDR_W   7   RAM address width; must hold address 64
//  BURST    8   words per filter region; fixed by the address map, do not change
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  clr        in   1        synchronous local clear; same effect as reset
//  wr_start   in   1        start a burst; sampled only in IDLE
//  F          in   3        filter-size select; latched on an accepted wr_start
//  in_valid   in   1        weight word valid
//  in_data    in   DATA_W   weight word
//  in_ready   out  1        block accepts in_data this cycle
//  ram_we     out  1        RAM write enable
//  ram_addr   out  ADDR_W   RAM write address
//  ram_wdata  out  DATA_W   RAM write data
//  busy       out  1        high from the cycle after an accepted start until done inclusive
//  done       out  1        one-cycle pulse on the final write of a burst
//  wr_count   out  4        words accepted in the current burst, 0..8
// BEHAVIOUR
//  Reset/clr: state=IDLE; outputs in_ready, ram_we, busy, done = 0; ram_addr, ram_wdata, wr_count = 0.
//   reset has priority over clr, and clr over all other inputs.
//  FSM states: IDLE, LOAD, DONE.
//  IDLE
//   - in_ready=0 and busy=0.
//   - On wr_start=1: latch base = {F,3'b000}+1 as a 7-bit value, clear idx and wr_count, go to LOAD.
//  LOAD
//   - in_ready=1 and busy=1.
//   - A word is accepted when in_valid && in_ready.
//   - On accept: next cycle ram_we=1, ram_addr=base+idx, ram_wdata=in_data (1-cycle latency); idx and wr_count increment.
//   - Cycles with no accept: ram_we=0 next cycle; ram_addr and ram_wdata hold their values.
//   - Accept of the 8th word (idx=7): in_ready is 0 from the next cycle; go to DONE.
//  DONE (exactly one cycle)
//   - ram_we=1 for the 8th write; done=1; busy=1; in_ready=0.
//   - Next state IDLE, with busy=0 and done=0.
//  Additional rules:
//   - wr_start in LOAD or DONE is ignored; F changes after the latch are ignored.
//   - Back-to-back: wr_start in the cycle after DONE starts a new burst; the minimum idle gap is 1 cycle.
//   - Addresses never wrap: the maximum is base 57 + 7 = 64, which fits in 7 bits.
//   - Words are written in stream order; no reordering; no beats are dropped while in_ready=1.
//   - in_data is not sampled when in_valid=0 or in_ready=0.
//   - reset/clr mid-burst abandons it: no done; already-written words stay in RAM; the next burst restarts at idx 0.
//   - wr_count stays at 8 after DONE until the next accepted wr_start clears it.
// TESTING
//  T1 reset: assert reset mid-LOAD after 3 words -> all outputs 0 immediately, state IDLE, no done.
//  T2 F=0, wr_start, 8 words 0x11..0x18 with in_valid held high
//     -> writes addr 1..8 on consecutive cycles starting 1 cycle after the first accept;
//        done coincides with the addr-8 write; busy for 9 cycles.
//  T3 F=7, in_valid toggled 1,0,1,0 -> writes addr 57..64 only on accepted beats;
//     gaps show ram_we=0; addr 64 carries word 8; done=1.
//  T4 F=3, wr_start re-pulsed with F=5 during LOAD -> ignored; all writes land in 25..32.
//  T5 clr after 5 words of F=2, then new burst with F=2 -> second burst writes 17..24 from idx 0; first burst gives no done.
//  T6 back-to-back: F=1 burst, wr_start on the cycle after done with F=4
//     -> writes 9..16 then 33..40; exactly two done pulses; in_ready low in IDLE/DONE.

Source files
------------

// File: rtl/ctrl_cct_kw_store.sv
// Kernel-weight RAM write controller.
// Streams one 8-word burst into the selected filter region.
module ctrl_cct_kw_store #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int BURST  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_start,
  input  logic [2:0]        F,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic [3:0]        wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] base;
  logic [3:0]        cnt;
  logic              accept;
  logic              start;

  assign wr_count = cnt;
  assign start    = (state == IDLE) && wr_start;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_start) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid;
        if (in_valid && cnt == 4'(BURST - 1))
          state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Write port is registered: each accepted beat lands one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (clr) begin
      state     <= IDLE;
      base      <= '0;
      cnt       <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state  <= state_nx;
      ram_we <= accept;
      if (accept) begin
        ram_addr  <= base + ADDR_W'(cnt);
        ram_wdata <= in_data;
        cnt       <= cnt + 4'd1;
      end
      if (start) begin
        base <= ADDR_W'({F, 3'b000}) + ADDR_W'(1);
        cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_cct_kw_store.sv
// Bench for ctrl_cct_kw_store: directed bursts plus randomized
// bursts checked against a per-beat address/data model.
module tb_ctrl_cct_kw_store;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       wr_start;
  logic [2:0] f_sel;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ram_we;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       busy;
  logic       done;
  logic [3:0] wr_count;

  int total = 0;
  int bad   = 0;
  int last_addr = 0;
  int last_data = 0;
  int done_seen = 0;

  ctrl_cct_kw_store dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .wr_start (wr_start),
    .F        (f_sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_we"}, 32'(ram_we), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cnt"}, 32'(wr_count), 0);
  endtask

  // mode: 0 valid always, 1 toggle 1/0, 2 random
  task automatic burst(input int f, input int mode, input int abort_n,
                       input bit use_clr, input int repulse_f,
                       input bit seq_data);
    logic [7:0] dat[8];
    int k;
    int it;
    bit v;
    for (int i = 0; i < 8; i++)
      dat[i] = seq_data ? 8'(8'h11 + i) : 8'($urandom);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(in_ready), 0);
    chk("idle_done", 32'(done), 0);
    wr_start = 1'b1;
    f_sel    = 3'(f);
    @(negedge clk);
    wr_start = (repulse_f >= 0);
    f_sel    = (repulse_f >= 0) ? 3'(repulse_f) : 3'(f);
    chk("start_we", 32'(ram_we), 0);
    k  = 0;
    it = 0;
    while (k < 8) begin
      chk("load_busy", 32'(busy), 1);
      chk("load_ready", 32'(in_ready), 1);
      chk("load_cnt", 32'(wr_count), 32'(k));
      if (k == abort_n) begin
        if (use_clr) begin
          clr = 1'b1;
          @(negedge clk);
          clr = 1'b0;
          chk_zero("clr");
        end else begin
          reset = 1'b1;
          #1;
          chk_zero("rst");
          @(negedge clk);
          reset = 1'b0;
        end
        last_addr = 0;
        last_data = 0;
        @(negedge clk);
        chk("abort_done", 32'(done), 0);
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (it % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1) || (it > 40);
      endcase
      in_valid = v;
      in_data  = v ? dat[k] : 8'($urandom);
      @(negedge clk);
      wr_start = 1'b0;
      f_sel    = 3'($urandom);
      in_valid = 1'b0;
      chk("we", 32'(ram_we), 32'(v));
      if (v) begin
        last_addr = 8 * f + 1 + k;
        last_data = int'(dat[k]);
        k++;
      end
      chk("addr", 32'(ram_addr), 32'(last_addr));
      chk("wdata", 32'(ram_wdata), 32'(last_data));
      chk("done", 32'(done), 32'(k == 8));
      if (done === 1'b1) done_seen++;
      it++;
    end
    chk("dn_busy", 32'(busy), 1);
    chk("dn_ready", 32'(in_ready), 0);
    chk("dn_cnt", 32'(wr_count), 8);
    @(negedge clk);
    chk("post_we", 32'(ram_we), 0);
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_cnt", 32'(wr_count), 8);
  endtask

  initial begin
    reset    = 1'b1;
    clr      = 1'b0;
    wr_start = 1'b0;
    f_sel    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // T1: reset after 3 words
    burst(6, 0, 3, 1'b0, -1, 1'b0);
    // T2: F=0, back-to-back stream of 0x11..0x18
    burst(0, 0, -1, 1'b0, -1, 1'b1);
    @(negedge clk);
    // T3: F=7, toggled valid
    burst(7, 1, -1, 1'b0, -1, 1'b0);
    @(negedge clk);
    // T4: start re-pulsed with F=5 during load
    burst(3, 0, -1, 1'b0, 5, 1'b0);
    @(negedge clk);
    // T5: clr after 5 words, then the same region again
    burst(2, 0, 5, 1'b1, -1, 1'b0);
    burst(2, 2, -1, 1'b0, -1, 1'b0);
    // T6: back-to-back bursts
    done_seen = 0;
    burst(1, 0, -1, 1'b0, -1, 1'b0);
    burst(4, 2, -1, 1'b0, -1, 1'b0);
    chk("t6_dones", 32'(done_seen), 2);

    for (int n = 0; n < 20; n++) begin
      burst(int'($urandom_range(0, 7)), 2, -1, 1'b0, -1, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
